// File: rtl/ps2_host_tx_if.sv
// Command-side handshake between the keyboard command logic and the PS/2 host transmitter.
interface ps2_host_tx_if;
    logic [7:0] txData;
    logic       txValid;
    logic       txReady;
    logic       txDone;
    logic       txError;

    modport master (
        output txData,
        output txValid,
        input  txReady,
        input  txDone,
        input  txError
    );

    modport slave (
        input  txData,
        input  txValid,
        output txReady,
        output txDone,
        output txError
    );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter driving open-drain clock/data enables.
// Define PS2_TX_RESEND_EN to retry a failed frame up to two extra times before reporting txError.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES     = 5000,
    parameter int unsigned FIRST_EDGE_CYCLES  = 750000,
    parameter int unsigned BIT_TIMEOUT_CYCLES = 100000
) (
    input  logic         clock,
    input  logic         reset,
    ps2_host_tx_if.slave tx,
    input  logic         ps2ClkIn,
    input  logic         ps2DataIn,
    output logic         ps2ClkOe,
    output logic         ps2DataOe
);
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_INHIBIT  = 3'd1;
    localparam logic [2:0] ST_START    = 3'd2;
    localparam logic [2:0] ST_SEND     = 3'd3;
    localparam logic [2:0] ST_ACK      = 3'd4;
    localparam logic [2:0] ST_WAITIDLE = 3'd5;

    localparam int unsigned TMAX = (FIRST_EDGE_CYCLES > BIT_TIMEOUT_CYCLES) ?
                                   FIRST_EDGE_CYCLES : BIT_TIMEOUT_CYCLES;
    localparam int unsigned TW   = $clog2(TMAX + 1);
    localparam int unsigned IW   = $clog2(INHIBIT_CYCLES + 1);

    localparam logic [TW-1:0] FIRST_LIM = TW'(FIRST_EDGE_CYCLES - 1);
    localparam logic [TW-1:0] BIT_LIM   = TW'(BIT_TIMEOUT_CYCLES - 1);
    localparam logic [IW-1:0] INH_LIM   = IW'(INHIBIT_CYCLES - 1);

    logic [2:0]    state_q;
    logic          clk_oe_q, data_oe_q;
    logic [8:0]    frame_q;
    logic [3:0]    bit_idx_q;
    logic [IW-1:0] inh_cnt_q;
    logic [TW-1:0] timer_q;
    logic          seen_edge_q, ack_ok_q;
    logic          done_q, error_q;
`ifdef PS2_TX_RESEND_EN
    logic [1:0]    retry_q;
`endif

    // Synchronisers idle high so reset never fabricates a falling edge.
    logic clk_meta_q, clk_sync_q, clk_prev_q, data_meta_q, data_sync_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            clk_meta_q  <= 1'b1;
            clk_sync_q  <= 1'b1;
            clk_prev_q  <= 1'b1;
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
        end else begin
            clk_meta_q  <= ps2ClkIn;
            clk_sync_q  <= clk_meta_q;
            clk_prev_q  <= clk_sync_q;
            data_meta_q <= ps2DataIn;
            data_sync_q <= data_meta_q;
        end
    end

    logic          fall_edge, in_xfer, timeout, fail;
    logic [TW-1:0] tmo_limit;

    always_comb begin
        fall_edge = clk_prev_q & ~clk_sync_q;
        in_xfer   = (state_q == ST_SEND) || (state_q == ST_ACK) || (state_q == ST_WAITIDLE);
        tmo_limit = seen_edge_q ? BIT_LIM : FIRST_LIM;
        // A device edge in the same cycle as expiry keeps the transfer alive.
        timeout   = in_xfer && !fall_edge && (timer_q == tmo_limit);
        fail      = timeout ||
                    ((state_q == ST_WAITIDLE) && clk_sync_q && data_sync_q && !ack_ok_q);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            clk_oe_q    <= 1'b0;
            data_oe_q   <= 1'b0;
            frame_q     <= '0;
            bit_idx_q   <= '0;
            inh_cnt_q   <= '0;
            timer_q     <= '0;
            seen_edge_q <= 1'b0;
            ack_ok_q    <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
`ifdef PS2_TX_RESEND_EN
            retry_q     <= '0;
`endif
        end else begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
            if (in_xfer) begin
                timer_q <= fall_edge ? '0 : timer_q + 1'b1;
            end
            if (fail) begin
                data_oe_q <= 1'b0;
`ifdef PS2_TX_RESEND_EN
                if (retry_q != 2'd2) begin
                    retry_q   <= retry_q + 1'b1;
                    clk_oe_q  <= 1'b1;
                    inh_cnt_q <= '0;
                    state_q   <= ST_INHIBIT;
                end else begin
                    clk_oe_q <= 1'b0;
                    error_q  <= 1'b1;
                    state_q  <= ST_IDLE;
                end
`else
                clk_oe_q <= 1'b0;
                error_q  <= 1'b1;
                state_q  <= ST_IDLE;
`endif
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (tx.txValid) begin
                            frame_q   <= {~^tx.txData, tx.txData};
                            clk_oe_q  <= 1'b1;
                            inh_cnt_q <= '0;
                            state_q   <= ST_INHIBIT;
`ifdef PS2_TX_RESEND_EN
                            retry_q   <= '0;
`endif
                        end
                    end
                    ST_INHIBIT: begin
                        if (inh_cnt_q == INH_LIM) begin
                            data_oe_q <= 1'b1;
                            state_q   <= ST_START;
                        end else begin
                            inh_cnt_q <= inh_cnt_q + 1'b1;
                        end
                    end
                    ST_START: begin
                        clk_oe_q    <= 1'b0;
                        bit_idx_q   <= '0;
                        timer_q     <= '0;
                        seen_edge_q <= 1'b0;
                        state_q     <= ST_SEND;
                    end
                    ST_SEND: begin
                        if (fall_edge) begin
                            seen_edge_q <= 1'b1;
                            if (bit_idx_q == 4'd9) begin
                                data_oe_q <= 1'b0;
                                state_q   <= ST_ACK;
                            end else begin
                                data_oe_q <= ~frame_q[bit_idx_q];
                                bit_idx_q <= bit_idx_q + 1'b1;
                            end
                        end
                    end
                    ST_ACK: begin
                        if (fall_edge) begin
                            ack_ok_q <= ~data_sync_q;
                            state_q  <= ST_WAITIDLE;
                        end
                    end
                    ST_WAITIDLE: begin
                        if (clk_sync_q && data_sync_q) begin
                            done_q  <= 1'b1;
                            state_q <= ST_IDLE;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign ps2ClkOe   = clk_oe_q;
    assign ps2DataOe  = data_oe_q;
    assign tx.txReady = (state_q == ST_IDLE);
    assign tx.txDone  = done_q;
    assign tx.txError = error_q;
endmodule
